// File: rtl/arb_req_front_end.sv
// arb_req_front_end: requester-side front end for a round-robin arbiter.
// Buffers N client streams in small FIFOs, presents their non-empty state as
// the arbiter request vector, muxes the granted head onto a single tagged
// valid/ready output and returns yumi when that head is consumed. Malformed
// grants raise a sticky error; channels left waiting too long raise a sticky
// starvation flag.

// Per-channel FIFO. The caller only pushes when not full and only pops when
// not empty, so no overflow/underflow protection is needed here.
module arb_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               rd_ptr, wr_ptr;
  logic [CW-1:0]               count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module arb_req_front_end #(
  parameter int NUM_REQUESTERS = 4,
  parameter int WIDTH          = 8,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_REQUESTERS-1:0]         v_i,
  input  logic [NUM_REQUESTERS*WIDTH-1:0]   data_i,
  output logic [NUM_REQUESTERS-1:0]         ready_o,
  output logic [NUM_REQUESTERS-1:0]         reqs_o,
  input  logic [NUM_REQUESTERS-1:0]         grants_i,
  output logic                              yumi_o,
  output logic                              v_o,
  output logic [WIDTH-1:0]                  data_o,
  output logic [$clog2(NUM_REQUESTERS)-1:0] id_o,
  input  logic                              ready_i,
  output logic                              err_o,
  output logic [NUM_REQUESTERS-1:0]         starve_o
);
  localparam int N   = NUM_REQUESTERS;
  localparam int IDW = $clog2(NUM_REQUESTERS);
  localparam int SCW = $clog2(STARVE_LIMIT + 2);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]            full, empty, push, pop;
  logic [N-1:0][WIDTH-1:0] heads;
  logic                    grant_onehot, grant_legal, grant_bad;

  // Request and ready come from registered FIFO state only; reset masks them
  // so nothing is offered or accepted while held in reset.
  assign ready_o = ~full  & {N{~reset_i}};
  assign reqs_o  = ~empty & {N{~reset_i}};
  assign push    = v_i & ready_o;

  assign grant_onehot = (grants_i != '0) && ((grants_i & (grants_i - ONE)) == '0);
  assign grant_legal  = grant_onehot && ((grants_i & reqs_o) != '0);
  assign grant_bad    = (grants_i != '0) && !grant_legal;

  assign v_o    = grant_legal;
  assign yumi_o = v_o & ready_i;
  assign pop    = grants_i & {N{yumi_o}};

  // Output mux: head and index of the granted channel, zero when idle.
  always_comb begin
    data_o = '0;
    id_o   = '0;
    if (grant_legal) begin
      for (int k = 0; k < N; k++) begin
        if (grants_i[k]) begin
          data_o = heads[k];
          id_o   = IDW'(k);
        end
      end
    end
  end

  // Sticky protocol error on any malformed grant.
  always_ff @(posedge clk_i) begin
    if (reset_i)        err_o <= 1'b0;
    else if (grant_bad) err_o <= 1'b1;
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [SCW-1:0] wait_cnt;
    logic           starve_r;

    arb_req_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push    (push[k]),
      .pop     (pop[k]),
      .din     (data_i[k*WIDTH +: WIDTH]),
      .dout    (heads[k]),
      .full    (full[k]),
      .empty   (empty[k])
    );

    // Wait counter: counts requesting cycles without a pop, saturating one
    // past the limit; crossing the limit latches the starvation flag.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        wait_cnt <= '0;
        starve_r <= 1'b0;
      end else if (pop[k] || !reqs_o[k]) begin
        wait_cnt <= '0;
      end else if (wait_cnt <= SCW'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + SCW'(1);
        if (wait_cnt == SCW'(STARVE_LIMIT)) starve_r <= 1'b1;
      end
    end

    assign starve_o[k] = starve_r;
  end
endmodule

// File: tb/tb_arb_req_front_end.sv
// Bench for arb_req_front_end: vector table for the single-channel flows,
// scoreboard of expected {id,data} transfers checked on every yumi, a small
// round-robin arbiter model, and hand sequences for errors and starvation.
module tb_arb_req_front_end;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  v_i;
  logic [31:0] data_i;
  logic [3:0]  ready_o, reqs_o, grants_i, starve_o;
  logic        yumi_o, v_o, ready_i, err_o;
  logic [7:0]  data_o;
  logic [1:0]  id_o;

  logic [3:0]  grants_man, rr_grant;
  logic        arb_en, rr_found;
  logic [1:0]  rr_ptr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [1:0] id; logic [7:0] data; } xfer_t;
  xfer_t sb[$];

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  g;
    logic        rdy;
    logic [3:0]  e_ready;
    logic [3:0]  e_reqs;
    logic        e_v;
    logic [1:0]  e_id;
    logic [7:0]  e_data;
    logic        e_yumi;
  } vec_t;
  vec_t tbl[15];

  always #5 clk_i = ~clk_i;

  arb_req_front_end dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .reqs_o   (reqs_o),
    .grants_i (grants_i),
    .yumi_o   (yumi_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .id_o     (id_o),
    .ready_i  (ready_i),
    .err_o    (err_o),
    .starve_o (starve_o)
  );

  // Round-robin arbiter model: first requester at or after the pointer.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!rr_found && reqs_o[(int'(rr_ptr) + i) % 4]) begin
        rr_grant[(int'(rr_ptr) + i) % 4] = 1'b1;
        rr_found = 1'b1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (reset_i)              rr_ptr <= 2'd0;
    else if (arb_en && yumi_o) rr_ptr <= id_o + 2'd1;
  end

  assign grants_i = arb_en ? rr_grant : grants_man;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed transfer must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!reset_i && yumi_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", 32'(yumi_o), 32'd0);
      end else begin
        xfer_t e;
        e = sb.pop_front();
        chk("sb_id", 32'(id_o), 32'(e.id));
        chk("sb_data", 32'(data_o), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    v_i        = 4'h0;
    data_i     = '0;
    grants_man = 4'b0001;
    ready_i    = 1'b1;
    #1;
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_reqs", 32'(reqs_o), 32'h0);
    chk("rst_v", 32'(v_o), 32'h0);
    chk("rst_yumi", 32'(yumi_o), 32'h0);
    tick();
    tick();
    reset_i    = 1'b0;
    grants_man = 4'h0;
    ready_i    = 1'b0;
    #1;
    chk("post_rst_err", 32'(err_o), 32'h0);
    chk("post_rst_starve", 32'(starve_o), 32'h0);
    chk("post_rst_reqs", 32'(reqs_o), 32'h0);
  endtask

  initial begin
    reset_i    = 1'b1;
    v_i        = 4'h0;
    data_i     = '0;
    grants_man = 4'h0;
    ready_i    = 1'b0;
    arb_en     = 1'b0;

    //           v     d             g     rdy  e_rdy e_req e_v id  data   yumi
    tbl[0]  = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{4'h4, 32'h00A50000, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[2]  = '{4'h0, 32'h00000000, 4'h4, 1'b1, 4'hF, 4'h4, 1'b1, 2'd2, 8'hA5, 1'b1};
    tbl[3]  = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[4]  = '{4'h1, 32'h00000011, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[5]  = '{4'h1, 32'h00000022, 4'h0, 1'b0, 4'hF, 4'h1, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[6]  = '{4'h0, 32'h00000000, 4'h1, 1'b0, 4'hE, 4'h1, 1'b1, 2'd0, 8'h11, 1'b0};
    tbl[7]  = '{4'h0, 32'h00000000, 4'h1, 1'b0, 4'hE, 4'h1, 1'b1, 2'd0, 8'h11, 1'b0};
    tbl[8]  = '{4'h1, 32'h00000033, 4'h1, 1'b1, 4'hE, 4'h1, 1'b1, 2'd0, 8'h11, 1'b1};
    tbl[9]  = '{4'h0, 32'h00000000, 4'h1, 1'b1, 4'hF, 4'h1, 1'b1, 2'd0, 8'h22, 1'b1};
    tbl[10] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[11] = '{4'h2, 32'h00004400, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[12] = '{4'h2, 32'h00005500, 4'h2, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 8'h44, 1'b1};
    tbl[13] = '{4'h0, 32'h00000000, 4'h2, 1'b1, 4'hF, 4'h2, 1'b1, 2'd1, 8'h55, 1'b1};
    tbl[14] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0};

    do_reset();

    // Single-channel transfers, backpressure, full-FIFO and push+pop rows.
    for (int r = 0; r < 15; r++) begin
      v_i        = tbl[r].v;
      data_i     = tbl[r].d;
      grants_man = tbl[r].g;
      ready_i    = tbl[r].rdy;
      #1;
      chk($sformatf("t%0d_ready", r), 32'(ready_o), 32'(tbl[r].e_ready));
      chk($sformatf("t%0d_reqs", r), 32'(reqs_o), 32'(tbl[r].e_reqs));
      chk($sformatf("t%0d_v", r), 32'(v_o), 32'(tbl[r].e_v));
      chk($sformatf("t%0d_id", r), 32'(id_o), 32'(tbl[r].e_id));
      chk($sformatf("t%0d_data", r), 32'(data_o), 32'(tbl[r].e_data));
      chk($sformatf("t%0d_yumi", r), 32'(yumi_o), 32'(tbl[r].e_yumi));
      chk($sformatf("t%0d_err", r), 32'(err_o), 32'h0);
      for (int k = 0; k < 4; k++) begin
        if (tbl[r].v[k] && tbl[r].e_ready[k]) begin
          xfer_t x;
          x.id   = 2'(k);
          x.data = tbl[r].d[k*8 +: 8];
          sb.push_back(x);
        end
      end
      tick();
    end
    v_i = 4'h0; grants_man = 4'h0; ready_i = 1'b0;

    // All four channels loaded, round-robin arbiter, ready held high.
    arb_en  = 1'b1;
    ready_i = 1'b1;
    v_i     = 4'hF;
    data_i  = 32'hD3C2B1A0;
    for (int k = 0; k < 4; k++) begin
      xfer_t x;
      x.id   = 2'(k);
      x.data = data_i[k*8 +: 8];
      sb.push_back(x);
    end
    tick();
    v_i = 4'h0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr_yumi_c%0d", c), 32'(yumi_o), 32'h1);
      tick();
    end
    #1;
    chk("rr_sb_drained", 32'(sb.size()), 32'h0);
    chk("rr_reqs", 32'(reqs_o), 32'h0);
    chk("rr_starve", 32'(starve_o), 32'h0);
    arb_en  = 1'b0;
    ready_i = 1'b0;
    tick();

    // Multi-bit grant: suppressed transfer, sticky error.
    v_i    = 4'h3;
    data_i = 32'h00006677;
    tick();
    v_i        = 4'h0;
    grants_man = 4'b0011;
    ready_i    = 1'b1;
    #1;
    chk("multi_v", 32'(v_o), 32'h0);
    chk("multi_yumi", 32'(yumi_o), 32'h0);
    chk("multi_err_same", 32'(err_o), 32'h0);
    tick();
    grants_man = 4'h0;
    #1;
    chk("multi_err_next", 32'(err_o), 32'h1);
    chk("multi_no_pop", 32'(reqs_o), 32'h3);
    tick();
    chk("multi_err_hold", 32'(err_o), 32'h1);
    do_reset();

    // Grant to a channel that is not requesting.
    grants_man = 4'b0100;
    ready_i    = 1'b1;
    #1;
    chk("idle_grant_v", 32'(v_o), 32'h0);
    chk("idle_grant_yumi", 32'(yumi_o), 32'h0);
    tick();
    grants_man = 4'h0;
    #1;
    chk("idle_grant_err", 32'(err_o), 32'h1);
    do_reset();

    // Starvation: ch3 requests while grants are withheld.
    v_i    = 4'h8;
    data_i = 32'h99000000;
    tick();
    v_i = 4'h0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) chk("starve_c4", 32'(starve_o), 32'h0);
      if (c == 5) begin
        chk("starve_c5", 32'(starve_o), 32'h8);
        chk("starve_reqs", 32'(reqs_o), 32'h8);
      end
    end
    tick();
    chk("starve_sticky", 32'(starve_o), 32'h8);
    do_reset();
    chk("starve_cleared", 32'(starve_o), 32'h0);

    chk("sb_final_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
